// File: rtl/rps_match_ctrl_if.sv
// Player/host handshake and result bus of the rock-paper-scissors match controller.
// The controller is the slave; players, host and the LCD score driver sit on the master side.
interface rps_match_ctrl_if;
  logic       start;
  logic       a_valid;
  logic [1:0] a_move;
  logic       a_ready;
  logic       b_valid;
  logic [1:0] b_move;
  logic       b_ready;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [1:0] round_result;
  logic       result_valid;
  logic       match_over;
  logic [1:0] winner;

  modport master (
    output start, a_valid, a_move, b_valid, b_move,
    input  a_ready, b_ready, score_a, score_b, round_result,
           result_valid, match_over, winner
  );

  modport slave (
    input  start, a_valid, a_move, b_valid, b_move,
    output a_ready, b_ready, score_a, score_b, round_result,
           result_valid, match_over, winner
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects one move per player per round,
// judges it, keeps scores, holds each result for display and detects the match winner.
module rps_match_ctrl #(
  parameter int unsigned WIN_SCORE      = 3,
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input logic            clk,
  input logic            rst_n,
  rps_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_JUDGE, S_HOLD, S_OVER} state_t;

  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [3:0]  WIN4      = 4'(WIN_SCORE);

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic        a_got, a_got_nx, b_got, b_got_nx;
  logic [1:0]  a_mv, a_mv_nx, b_mv, b_mv_nx;
  logic        a_rdy, a_rdy_nx, b_rdy, b_rdy_nx;
  logic [3:0]  sc_a, sc_a_nx, sc_b, sc_b_nx;
  logic [1:0]  rr, rr_nx, win, win_nx;
  logic        rv, rv_nx, over, over_nx;
  logic        acc_a, acc_b;

  // Illegal move (00) completes the handshake but is never latched.
  assign acc_a = bus.a_valid && a_rdy && (bus.a_move != 2'b00);
  assign acc_b = bus.b_valid && b_rdy && (bus.b_move != 2'b00);

  function automatic logic a_beats(input logic [1:0] x, input logic [1:0] y);
    return (x == 2'b01 && y == 2'b10) || (x == 2'b10 && y == 2'b11) ||
           (x == 2'b11 && y == 2'b01);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_got <= 1'b0;
      b_got <= 1'b0;
      a_mv  <= '0;
      b_mv  <= '0;
      a_rdy <= 1'b0;
      b_rdy <= 1'b0;
      sc_a  <= '0;
      sc_b  <= '0;
      rr    <= '0;
      rv    <= 1'b0;
      over  <= 1'b0;
      win   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      a_got <= a_got_nx;
      b_got <= b_got_nx;
      a_mv  <= a_mv_nx;
      b_mv  <= b_mv_nx;
      a_rdy <= a_rdy_nx;
      b_rdy <= b_rdy_nx;
      sc_a  <= sc_a_nx;
      sc_b  <= sc_b_nx;
      rr    <= rr_nx;
      rv    <= rv_nx;
      over  <= over_nx;
      win   <= win_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_got_nx = a_got;
    b_got_nx = b_got;
    a_mv_nx  = a_mv;
    b_mv_nx  = b_mv;
    a_rdy_nx = a_rdy;
    b_rdy_nx = b_rdy;
    sc_a_nx  = sc_a;
    sc_b_nx  = sc_b;
    rr_nx    = rr;
    rv_nx    = 1'b0;
    over_nx  = over;
    win_nx   = win;
    case (state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_nx = S_COLLECT;
          cnt_nx   = '0;
          a_got_nx = 1'b0;
          b_got_nx = 1'b0;
          a_rdy_nx = 1'b1;
          b_rdy_nx = 1'b1;
          sc_a_nx  = '0;
          sc_b_nx  = '0;
          rr_nx    = '0;
          over_nx  = 1'b0;
          win_nx   = '0;
        end
      end
      S_COLLECT: begin
        cnt_nx = cnt + 32'd1;
        if (a_got && b_got) begin
          state_nx = S_JUDGE;
        end else begin
          if (acc_a) begin
            a_got_nx = 1'b1;
            a_mv_nx  = bus.a_move;
          end
          if (acc_b) begin
            b_got_nx = 1'b1;
            b_mv_nx  = bus.b_move;
          end
          a_rdy_nx = !a_got_nx;
          b_rdy_nx = !b_got_nx;
          // A move accepted on the timeout edge is already in *_got_nx and still counts.
          if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST && !(a_got_nx && b_got_nx)) begin
            state_nx = S_JUDGE;
            a_rdy_nx = 1'b0;
            b_rdy_nx = 1'b0;
          end
        end
      end
      S_JUDGE: begin
        state_nx = S_HOLD;
        cnt_nx   = '0;
        rv_nx    = 1'b1;
        if (a_got && b_got)
          rr_nx = (a_mv == b_mv) ? 2'b11 : (a_beats(a_mv, b_mv) ? 2'b01 : 2'b10);
        else if (a_got)
          rr_nx = 2'b01;
        else if (b_got)
          rr_nx = 2'b10;
        else
          rr_nx = 2'b11;
        if (rr_nx == 2'b01 && sc_a < WIN4) sc_a_nx = sc_a + 4'd1;
        if (rr_nx == 2'b10 && sc_b < WIN4) sc_b_nx = sc_b + 4'd1;
      end
      S_HOLD: begin
        cnt_nx = cnt + 32'd1;
        if (cnt == HOLD_LAST) begin
          if (sc_a == WIN4 || sc_b == WIN4) begin
            state_nx = S_OVER;
            over_nx  = 1'b1;
            win_nx   = (sc_a == WIN4) ? 2'b01 : 2'b10;
          end else begin
            state_nx = S_COLLECT;
            cnt_nx   = '0;
            a_got_nx = 1'b0;
            b_got_nx = 1'b0;
            a_rdy_nx = 1'b1;
            b_rdy_nx = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.a_ready      = a_rdy;
  assign bus.b_ready      = b_rdy;
  assign bus.score_a      = sc_a;
  assign bus.score_b      = sc_b;
  assign bus.round_result = rr;
  assign bus.result_valid = rv;
  assign bus.match_over   = over;
  assign bus.winner       = win;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl (HOLD_CYCLES=4, TIMEOUT_CYCLES=20, WIN_SCORE=3).
module tb_rps_match_ctrl;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rps_match_ctrl_if bus ();

  rps_match_ctrl #(
    .WIN_SCORE     (3),
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.a_ready && n < 40);
    check(tag, 32'(bus.a_ready), 32'd1);
  endtask

  // Drives both moves for one cycle, returns just after the HOLD-entry edge.
  task automatic round_both(input logic [1:0] am, input logic [1:0] bm);
    bus.a_valid = 1'b1; bus.a_move = am;
    bus.b_valid = 1'b1; bus.b_move = bm;
    step(1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a_valid = 1'b0; bus.a_move = 2'b00;
    bus.b_valid = 1'b0; bus.b_move = 2'b00;
    step(2);
    check("rst_a_ready", 32'(bus.a_ready), 0);
    check("rst_score_a", 32'(bus.score_a), 0);
    check("rst_rr", 32'(bus.round_result), 0);
    check("rst_over", 32'(bus.match_over), 0);
    rst_n = 1'b1;
    step(1);

    // Round 1: start with valids in IDLE (ignored), then A rock vs B scissors
    bus.start = 1'b1;
    bus.a_valid = 1'b1; bus.a_move = 2'b01;
    bus.b_valid = 1'b1; bus.b_move = 2'b10;
    step(1);
    check("start_a_ready", 32'(bus.a_ready), 1);
    check("start_b_ready", 32'(bus.b_ready), 1);
    bus.start = 1'b0;
    step(1);
    check("r1_ready_drop", 32'(bus.a_ready), 0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step(1);
    check("r1_rv_early", 32'(bus.result_valid), 0);
    step(1);
    check("r1_rv", 32'(bus.result_valid), 1);
    check("r1_rr", 32'(bus.round_result), 2'b01);
    check("r1_score_a", 32'(bus.score_a), 1);
    step(1);
    check("r1_rv_pulse", 32'(bus.result_valid), 0);
    wait_ready("r1_back_collect");

    // Round 2: paper vs paper draw; exact HOLD length
    round_both(2'b11, 2'b11);
    check("r2_rr", 32'(bus.round_result), 2'b11);
    check("r2_score_a", 32'(bus.score_a), 1);
    check("r2_score_b", 32'(bus.score_b), 0);
    step(3);
    check("r2_hold_ready", 32'(bus.a_ready), 0);
    step(1);
    check("r2_collect_ready", 32'(bus.a_ready), 1);

    // Round 3: A rock latched, later A paper ignored, B 00 discarded, then B paper
    bus.a_valid = 1'b1; bus.a_move = 2'b01;
    step(1);
    check("r3_a_ready", 32'(bus.a_ready), 0);
    check("r3_b_ready", 32'(bus.b_ready), 1);
    bus.a_move = 2'b11;
    bus.b_valid = 1'b1; bus.b_move = 2'b00;
    step(1);
    check("r3_b_illegal", 32'(bus.b_ready), 1);
    bus.b_move = 2'b11;
    step(1);
    check("r3_b_latched", 32'(bus.b_ready), 0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step(2);
    check("r3_rr", 32'(bus.round_result), 2'b10);
    check("r3_score_b", 32'(bus.score_b), 1);
    wait_ready("r3_back_collect");

    // Rounds 4-5: A wins to 3 -> OVER
    round_both(2'b01, 2'b10);
    check("r4_score_a", 32'(bus.score_a), 2);
    wait_ready("r4_back_collect");
    round_both(2'b10, 2'b11);
    check("r5_score_a", 32'(bus.score_a), 3);
    step(3);
    check("r5_not_over", 32'(bus.match_over), 0);
    step(1);
    check("over", 32'(bus.match_over), 1);
    check("over_winner", 32'(bus.winner), 2'b01);
    check("over_ready", 32'(bus.a_ready | bus.b_ready), 0);
    check("over_score_b", 32'(bus.score_b), 1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("restart_score_a", 32'(bus.score_a), 0);
    check("restart_score_b", 32'(bus.score_b), 0);
    check("restart_rr", 32'(bus.round_result), 0);
    check("restart_over", 32'(bus.match_over), 0);
    check("restart_winner", 32'(bus.winner), 0);
    check("restart_ready", 32'(bus.b_ready), 1);

    // Timeout: only B moves, A forfeits at the 20th COLLECT edge
    bus.b_valid = 1'b1; bus.b_move = 2'b10;
    step(1);
    bus.b_valid = 1'b0;
    step(18);
    check("to1_pre_a_ready", 32'(bus.a_ready), 1);
    step(1);
    check("to1_judge_ready", 32'(bus.a_ready), 0);
    step(1);
    check("to1_rv", 32'(bus.result_valid), 1);
    check("to1_rr", 32'(bus.round_result), 2'b10);
    check("to1_score_b", 32'(bus.score_b), 1);
    wait_ready("to1_back_collect");

    // Timeout with no moves -> draw
    step(19);
    check("to2_pre_ready", 32'(bus.a_ready), 1);
    step(1);
    check("to2_judge_ready", 32'(bus.a_ready), 0);
    step(1);
    check("to2_rr", 32'(bus.round_result), 2'b11);
    check("to2_score_a", 32'(bus.score_a), 0);
    check("to2_score_b", 32'(bus.score_b), 1);
    wait_ready("to2_back_collect");

    // A's legal move on the timeout edge counts
    step(19);
    bus.a_valid = 1'b1; bus.a_move = 2'b01;
    step(1);
    bus.a_valid = 1'b0;
    check("to3_ready", 32'(bus.a_ready), 0);
    step(1);
    check("to3_rr", 32'(bus.round_result), 2'b01);
    check("to3_score_a", 32'(bus.score_a), 1);
    wait_ready("to3_back_collect");

    // Reset during HOLD with score_a=2
    round_both(2'b01, 2'b10);
    check("pre_rst_score_a", 32'(bus.score_a), 2);
    step(1);
    rst_n = 1'b0;
    step(1);
    check("hrst_score_a", 32'(bus.score_a), 0);
    check("hrst_score_b", 32'(bus.score_b), 0);
    check("hrst_rr", 32'(bus.round_result), 0);
    check("hrst_ready", 32'(bus.a_ready | bus.b_ready), 0);
    rst_n = 1'b1;
    bus.a_valid = 1'b1; bus.a_move = 2'b01;
    bus.b_valid = 1'b1; bus.b_move = 2'b10;
    step(3);
    check("idle_ignore_ready", 32'(bus.a_ready), 0);
    check("idle_ignore_rv", 32'(bus.result_valid), 0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("post_start_ready", 32'(bus.a_ready & bus.b_ready), 1);
    step(1);
    check("post_accept", 32'(bus.a_ready), 0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step(2);
    check("post_rr", 32'(bus.round_result), 2'b01);
    check("post_score_a", 32'(bus.score_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
